// File: rtl/mem_arbiter_2x1_pkg.sv
// mem_arb_pkg: shared types for the two-master memory channel arbiter.
//   rd_state_e / wr_state_e : 2-bit read and write path FSM encodings
//   mst_idx_t               : master index (0 or 1)
//   RR_PTR_RST              : reset value of the "last granted" pointer;
//                             pointing at m1 makes m0 win the first tie.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_XFER = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef logic mst_idx_t;

    localparam mst_idx_t RR_PTR_RST = 1'b1;

endpackage

// File: rtl/mem_arbiter_2x1_rr_picker.sv
// mem_arb_rr_picker: two-way request picker for one arbitration path.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : request vector, bit N = master N requesting
//   upd       : strobe, a transaction of master done_idx has completed
//   done_idx  : master whose transaction completed
//   win_idx   : combinational winner for the current request vector
// Build option MEM_ARB_RR_EN: when defined, ties alternate (the master that
// did not complete last wins); when undefined, m0 always wins ties and the
// pointer register does not exist.
module mem_arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  mst_idx_t   done_idx,
    output mst_idx_t   win_idx
);

    mst_idx_t tie_win_s;

`ifdef MEM_ARB_RR_EN
    mst_idx_t last_r;

    // Remember which master completed most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= RR_PTR_RST;
        end else if (upd) begin
            last_r <= done_idx;
        end else begin
            last_r <= last_r;
        end
    end

    assign tie_win_s = ~last_r;
`else
    logic unused_s;

    assign tie_win_s = 1'b0;
    assign unused_s  = ^{clk, rst, upd, done_idx};
`endif

    // Resolve the winner: a lone requester always wins, ties use tie_win_s.
    always_comb begin
        win_idx = 1'b0;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = tie_win_s;
            default: win_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_2x1.sv
// mem_arbiter_2x1: shares one memory's AR/R and AW/W/B channel set between
// two masters. Read and write paths are arbitrated independently; each is
// locked to one master from address handshake to response handshake.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mN_ar_*, mN_r_*          : read address / data channels of master N
//   mN_aw_*, mN_w_*, mN_b_*  : write address / data / response of master N
//   s_*                      : memory-side channels (directions mirrored)
//   rd_owner, rd_busy        : read grant index and read-path lock
//   wr_owner, wr_busy        : write grant index and write-path lock
// Build option MEM_ARB_RR_EN: round-robin ties when defined, fixed m0
// priority otherwise (see mem_arb_rr_picker).
module mem_arbiter_2x1
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    // master 0
    input  logic                 m0_ar_valid,
    output logic                 m0_ar_ready,
    input  logic [ADDR_WDTH-1:0] m0_ar_address,
    output logic                 m0_r_valid,
    input  logic                 m0_r_ready,
    output logic [DATA_WDTH-1:0] m0_r_data,
    output logic [RESP_WDTH-1:0] m0_r_resp,
    input  logic                 m0_aw_valid,
    output logic                 m0_aw_ready,
    input  logic [ADDR_WDTH-1:0] m0_aw_address,
    input  logic                 m0_w_valid,
    output logic                 m0_w_ready,
    input  logic [DATA_WDTH-1:0] m0_w_data,
    output logic                 m0_b_valid,
    input  logic                 m0_b_ready,
    output logic [RESP_WDTH-1:0] m0_b_resp,
    // master 1
    input  logic                 m1_ar_valid,
    output logic                 m1_ar_ready,
    input  logic [ADDR_WDTH-1:0] m1_ar_address,
    output logic                 m1_r_valid,
    input  logic                 m1_r_ready,
    output logic [DATA_WDTH-1:0] m1_r_data,
    output logic [RESP_WDTH-1:0] m1_r_resp,
    input  logic                 m1_aw_valid,
    output logic                 m1_aw_ready,
    input  logic [ADDR_WDTH-1:0] m1_aw_address,
    input  logic                 m1_w_valid,
    output logic                 m1_w_ready,
    input  logic [DATA_WDTH-1:0] m1_w_data,
    output logic                 m1_b_valid,
    input  logic                 m1_b_ready,
    output logic [RESP_WDTH-1:0] m1_b_resp,
    // memory side
    output logic                 s_ar_valid,
    input  logic                 s_ar_ready,
    output logic [ADDR_WDTH-1:0] s_ar_address,
    input  logic                 s_r_valid,
    output logic                 s_r_ready,
    input  logic [DATA_WDTH-1:0] s_r_data,
    input  logic [RESP_WDTH-1:0] s_r_resp,
    output logic                 s_aw_valid,
    input  logic                 s_aw_ready,
    output logic [ADDR_WDTH-1:0] s_aw_address,
    output logic                 s_w_valid,
    input  logic                 s_w_ready,
    output logic [DATA_WDTH-1:0] s_w_data,
    input  logic                 s_b_valid,
    output logic                 s_b_ready,
    input  logic [RESP_WDTH-1:0] s_b_resp,
    // status
    output logic                 rd_owner,
    output logic                 rd_busy,
    output logic                 wr_owner,
    output logic                 wr_busy
);

    rd_state_e rd_state_r, rd_state_nxt_s;
    mst_idx_t  rd_owner_r, rd_owner_nxt_s, rd_win_s;
    logic      rd_upd_s, rd_busy_r;

    wr_state_e wr_state_r, wr_state_nxt_s;
    mst_idx_t  wr_owner_r, wr_owner_nxt_s, wr_win_s;
    logic      wr_upd_s, wr_busy_r;
    logic      aw_done_r, aw_done_nxt_s, w_done_r, w_done_nxt_s;
    logic      aw_hs_s, w_hs_s;

    mem_arb_rr_picker u_rd_pick (
        .clk      (clk),
        .rst      (rst),
        .req      ({m1_ar_valid, m0_ar_valid}),
        .upd      (rd_upd_s),
        .done_idx (rd_owner_r),
        .win_idx  (rd_win_s)
    );

    mem_arb_rr_picker u_wr_pick (
        .clk      (clk),
        .rst      (rst),
        .req      ({m1_aw_valid, m0_aw_valid}),
        .upd      (wr_upd_s),
        .done_idx (wr_owner_r),
        .win_idx  (wr_win_s)
    );

    // Read path state, grant and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= RD_IDLE;
            rd_owner_r <= 1'b0;
            rd_busy_r  <= 1'b0;
        end else begin
            rd_state_r <= rd_state_nxt_s;
            rd_owner_r <= rd_owner_nxt_s;
            rd_busy_r  <= (rd_state_nxt_s != RD_IDLE);
        end
    end

    // Read path next state and channel routing to the owner.
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        rd_owner_nxt_s = rd_owner_r;
        rd_upd_s       = 1'b0;
        s_ar_valid     = 1'b0;
        s_ar_address   = {ADDR_WDTH{1'b0}};
        s_r_ready      = 1'b0;
        m0_ar_ready    = 1'b0;
        m1_ar_ready    = 1'b0;
        m0_r_valid     = 1'b0;
        m1_r_valid     = 1'b0;
        m0_r_data      = {DATA_WDTH{1'b0}};
        m1_r_data      = {DATA_WDTH{1'b0}};
        m0_r_resp      = {RESP_WDTH{1'b0}};
        m1_r_resp      = {RESP_WDTH{1'b0}};
        case (rd_state_r)
            RD_IDLE: begin
                if (m0_ar_valid | m1_ar_valid) begin
                    rd_state_nxt_s = RD_ADDR;
                    rd_owner_nxt_s = rd_win_s;
                end else begin
                    rd_state_nxt_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (rd_owner_r) begin
                    s_ar_valid   = m1_ar_valid;
                    s_ar_address = m1_ar_address;
                    m1_ar_ready  = s_ar_ready;
                end else begin
                    s_ar_valid   = m0_ar_valid;
                    s_ar_address = m0_ar_address;
                    m0_ar_ready  = s_ar_ready;
                end
                if (s_ar_valid & s_ar_ready) begin
                    rd_state_nxt_s = RD_DATA;
                end else begin
                    rd_state_nxt_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rd_owner_r) begin
                    s_r_ready  = m1_r_ready;
                    m1_r_valid = s_r_valid;
                    m1_r_data  = s_r_data;
                    m1_r_resp  = s_r_resp;
                end else begin
                    s_r_ready  = m0_r_ready;
                    m0_r_valid = s_r_valid;
                    m0_r_data  = s_r_data;
                    m0_r_resp  = s_r_resp;
                end
                if (s_r_valid & s_r_ready) begin
                    rd_state_nxt_s = RD_IDLE;
                    rd_upd_s       = 1'b1;
                end else begin
                    rd_state_nxt_s = RD_DATA;
                end
            end
            default: begin
                rd_state_nxt_s = RD_IDLE;
            end
        endcase
    end

    // Write path state, grant, handshake flags and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= WR_IDLE;
            wr_owner_r <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            wr_busy_r  <= 1'b0;
        end else begin
            wr_state_r <= wr_state_nxt_s;
            wr_owner_r <= wr_owner_nxt_s;
            aw_done_r  <= aw_done_nxt_s;
            w_done_r   <= w_done_nxt_s;
            wr_busy_r  <= (wr_state_nxt_s != WR_IDLE);
        end
    end

    // Write path next state and routing; AW and W complete independently
    // and a finished channel is shut off until the response phase.
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        wr_owner_nxt_s = wr_owner_r;
        wr_upd_s       = 1'b0;
        aw_done_nxt_s  = aw_done_r;
        w_done_nxt_s   = w_done_r;
        aw_hs_s        = 1'b0;
        w_hs_s         = 1'b0;
        s_aw_valid     = 1'b0;
        s_aw_address   = {ADDR_WDTH{1'b0}};
        s_w_valid      = 1'b0;
        s_w_data       = {DATA_WDTH{1'b0}};
        s_b_ready      = 1'b0;
        m0_aw_ready    = 1'b0;
        m1_aw_ready    = 1'b0;
        m0_w_ready     = 1'b0;
        m1_w_ready     = 1'b0;
        m0_b_valid     = 1'b0;
        m1_b_valid     = 1'b0;
        m0_b_resp      = {RESP_WDTH{1'b0}};
        m1_b_resp      = {RESP_WDTH{1'b0}};
        case (wr_state_r)
            WR_IDLE: begin
                if (m0_aw_valid | m1_aw_valid) begin
                    wr_state_nxt_s = WR_XFER;
                    wr_owner_nxt_s = wr_win_s;
                end else begin
                    wr_state_nxt_s = WR_IDLE;
                end
            end
            WR_XFER: begin
                if (!aw_done_r) begin
                    if (wr_owner_r) begin
                        s_aw_valid   = m1_aw_valid;
                        s_aw_address = m1_aw_address;
                        m1_aw_ready  = s_aw_ready;
                    end else begin
                        s_aw_valid   = m0_aw_valid;
                        s_aw_address = m0_aw_address;
                        m0_aw_ready  = s_aw_ready;
                    end
                    aw_hs_s = s_aw_valid & s_aw_ready;
                end else begin
                    aw_hs_s = 1'b0;
                end
                if (!w_done_r) begin
                    if (wr_owner_r) begin
                        s_w_valid  = m1_w_valid;
                        s_w_data   = m1_w_data;
                        m1_w_ready = s_w_ready;
                    end else begin
                        s_w_valid  = m0_w_valid;
                        s_w_data   = m0_w_data;
                        m0_w_ready = s_w_ready;
                    end
                    w_hs_s = s_w_valid & s_w_ready;
                end else begin
                    w_hs_s = 1'b0;
                end
                aw_done_nxt_s = aw_done_r | aw_hs_s;
                w_done_nxt_s  = w_done_r | w_hs_s;
                if (aw_done_nxt_s & w_done_nxt_s) begin
                    wr_state_nxt_s = WR_RESP;
                    aw_done_nxt_s  = 1'b0;
                    w_done_nxt_s   = 1'b0;
                end else begin
                    wr_state_nxt_s = WR_XFER;
                end
            end
            WR_RESP: begin
                if (wr_owner_r) begin
                    s_b_ready  = m1_b_ready;
                    m1_b_valid = s_b_valid;
                    m1_b_resp  = s_b_resp;
                end else begin
                    s_b_ready  = m0_b_ready;
                    m0_b_valid = s_b_valid;
                    m0_b_resp  = s_b_resp;
                end
                if (s_b_valid & s_b_ready) begin
                    wr_state_nxt_s = WR_IDLE;
                    wr_upd_s       = 1'b1;
                end else begin
                    wr_state_nxt_s = WR_RESP;
                end
            end
            default: begin
                wr_state_nxt_s = WR_IDLE;
                aw_done_nxt_s  = 1'b0;
                w_done_nxt_s   = 1'b0;
            end
        endcase
    end

    assign rd_owner = rd_owner_r;
    assign rd_busy  = rd_busy_r;
    assign wr_owner = wr_owner_r;
    assign wr_busy  = wr_busy_r;

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed bench for mem_arbiter_2x1: a table of read transactions plus
// hand-written write, concurrency and reset sequences. Expected grant order
// for ties follows MEM_ARB_RR_EN.
module tb_mem_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic [3:0]  m0_ar_address, m0_aw_address;
    logic [31:0] m0_r_data, m0_w_data;
    logic        m0_r_resp, m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_ready;
    logic        m0_b_valid, m0_b_ready, m0_b_resp;
    logic        m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic [3:0]  m1_ar_address, m1_aw_address;
    logic [31:0] m1_r_data, m1_w_data;
    logic        m1_r_resp, m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready;
    logic        m1_b_valid, m1_b_ready, m1_b_resp;
    logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_resp;
    logic [3:0]  s_ar_address, s_aw_address;
    logic [31:0] s_r_data, s_w_data;
    logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
    logic        s_b_valid, s_b_ready, s_b_resp;
    logic        rd_owner, rd_busy, wr_owner, wr_busy;

    int n_checks = 0;
    int n_errors = 0;

    // memory-side handshake monitor
    int          aw_cnt = 0;
    int          w_cnt = 0;
    logic [3:0]  aw_addr_q = 4'h0;
    logic [31:0] w_data_q = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter_2x1 dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_address(m0_ar_address),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_address(m0_aw_address),
        .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_data(m0_w_data),
        .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready), .m0_b_resp(m0_b_resp),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_address(m1_ar_address),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_address(m1_aw_address),
        .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data),
        .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready), .m1_b_resp(m1_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_address(s_ar_address),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_address(s_aw_address),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
        .rd_owner(rd_owner), .rd_busy(rd_busy), .wr_owner(wr_owner), .wr_busy(wr_busy)
    );

    // Count memory-side AW and W handshakes and capture what was transferred.
    always @(posedge clk) begin
        if (s_aw_valid && s_aw_ready) begin
            aw_cnt    <= aw_cnt + 1;
            aw_addr_q <= s_aw_address;
        end
        if (s_w_valid && s_w_ready) begin
            w_cnt    <= w_cnt + 1;
            w_data_q <= s_w_data;
        end
    end

    typedef struct {
        logic        m0_v;
        logic        m1_v;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic        exp_owner;
        logic [3:0]  exp_addr;
        logic [31:0] rdata;
        logic        rresp;
    } rd_vec_t;

    rd_vec_t vec [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_ar_valid = 1'b0; m0_ar_address = 4'h0; m0_r_ready = 1'b0;
        m0_aw_valid = 1'b0; m0_aw_address = 4'h0; m0_w_valid = 1'b0;
        m0_w_data = 32'h0; m0_b_ready = 1'b0;
        m1_ar_valid = 1'b0; m1_ar_address = 4'h0; m1_r_ready = 1'b0;
        m1_aw_valid = 1'b0; m1_aw_address = 4'h0; m1_w_valid = 1'b0;
        m1_w_data = 32'h0; m1_b_ready = 1'b0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = 32'h0; s_r_resp = 1'b0;
        s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0; s_b_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int aw0;
        int w0;
        logic own;

`ifdef MEM_ARB_RR_EN
        vec[0] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h11111111, 1'b0};
        vec[1] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b1, 4'h2, 32'h22222222, 1'b0};
        vec[2] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h33333333, 1'b0};
        vec[3] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b1, 4'h2, 32'h44444444, 1'b0};
`else
        vec[0] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h11111111, 1'b0};
        vec[1] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h22222222, 1'b0};
        vec[2] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h33333333, 1'b0};
        vec[3] = '{1'b1, 1'b1, 4'h1, 4'h2, 1'b0, 4'h1, 32'h44444444, 1'b0};
`endif
        vec[4] = '{1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0};
        vec[5] = '{1'b0, 1'b1, 4'h0, 4'h6, 1'b1, 4'h6, 32'hCAFEF00D, 1'b1};

        // reset state
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk1("rst_rd_busy", rd_busy, 1'b0);
        chk1("rst_wr_busy", wr_busy, 1'b0);
        chk1("rst_rd_owner", rd_owner, 1'b0);
        chk1("rst_wr_owner", wr_owner, 1'b0);
        rst = 1'b0;
        step();

        // table-driven read transactions
        for (int i = 0; i < 6; i++) begin
            own = vec[i].exp_owner;
            m0_ar_valid = vec[i].m0_v; m0_ar_address = vec[i].a0;
            m1_ar_valid = vec[i].m1_v; m1_ar_address = vec[i].a1;
            settle();
            chk1("rd_busy_before", rd_busy, 1'b0);
            chk1("s_ar_valid_idle", s_ar_valid, 1'b0);
            step();
            chk1("rd_busy_addr", rd_busy, 1'b1);
            chk1("rd_owner", rd_owner, own);
            chk1("s_ar_valid", s_ar_valid, 1'b1);
            chkw("s_ar_address", 32'(s_ar_address), 32'(vec[i].exp_addr));
            s_ar_ready = 1'b1;
            settle();
            chk1("m0_ar_ready", m0_ar_ready, ~own);
            chk1("m1_ar_ready", m1_ar_ready, own);
            step();
            m0_ar_valid = 1'b0; m1_ar_valid = 1'b0; s_ar_ready = 1'b0;
            s_r_valid = 1'b1; s_r_data = vec[i].rdata; s_r_resp = vec[i].rresp;
            m0_r_ready = 1'b1; m1_r_ready = 1'b1;
            settle();
            chk1("rd_busy_data", rd_busy, 1'b1);
            chk1("s_r_ready", s_r_ready, 1'b1);
            chk1("owner_r_valid", own ? m1_r_valid : m0_r_valid, 1'b1);
            chkw("owner_r_data", own ? m1_r_data : m0_r_data, vec[i].rdata);
            chk1("owner_r_resp", own ? m1_r_resp : m0_r_resp, vec[i].rresp);
            chk1("other_r_valid", own ? m0_r_valid : m1_r_valid, 1'b0);
            chkw("other_r_data", own ? m0_r_data : m1_r_data, 32'h0);
            chk1("other_r_resp", own ? m0_r_resp : m1_r_resp, 1'b0);
            step();
            idle_inputs();
            settle();
            chk1("rd_busy_after", rd_busy, 1'b0);
        end

        // write by m1 with W offered before AW, handshakes in different cycles
        aw0 = aw_cnt; w0 = w_cnt;
        m1_w_valid = 1'b1; m1_w_data = 32'h12345678;
        step();
        chk1("w_first_s_w_valid", s_w_valid, 1'b0);
        chk1("w_first_m1_w_ready", m1_w_ready, 1'b0);
        step();
        m1_aw_valid = 1'b1; m1_aw_address = 4'h5;
        settle();
        chk1("w_first_wr_busy", wr_busy, 1'b0);
        step();
        chk1("wr_busy_xfer", wr_busy, 1'b1);
        chk1("wr_owner_m1", wr_owner, 1'b1);
        chk1("s_aw_valid", s_aw_valid, 1'b1);
        chkw("s_aw_address", 32'(s_aw_address), 32'h5);
        chkw("s_w_data", s_w_data, 32'h12345678);
        s_aw_ready = 1'b1;
        settle();
        chk1("m1_aw_ready", m1_aw_ready, 1'b1);
        chk1("m0_aw_ready", m0_aw_ready, 1'b0);
        chk1("m1_w_ready_held", m1_w_ready, 1'b0);
        step();
        // AW done; master still shows aw_valid, which must be masked
        s_w_ready = 1'b1;
        settle();
        chk1("aw_masked_valid", s_aw_valid, 1'b0);
        chk1("aw_masked_ready", m1_aw_ready, 1'b0);
        chk1("m1_w_ready", m1_w_ready, 1'b1);
        step();
        idle_inputs();
        s_b_valid = 1'b1; s_b_resp = 1'b0; m0_b_ready = 1'b1; m1_b_ready = 1'b1;
        settle();
        chk1("wr_busy_resp", wr_busy, 1'b1);
        chk1("resp_s_w_valid", s_w_valid, 1'b0);
        chk1("m1_b_valid", m1_b_valid, 1'b1);
        chk1("m1_b_resp", m1_b_resp, 1'b0);
        chk1("m0_b_valid", m0_b_valid, 1'b0);
        chk1("s_b_ready", s_b_ready, 1'b1);
        step();
        idle_inputs();
        settle();
        chk1("wr_busy_done", wr_busy, 1'b0);
        chkw("aw_handshakes", 32'(aw_cnt - aw0), 32'h1);
        chkw("w_handshakes", 32'(w_cnt - w0), 32'h1);
        chkw("mem_addr", 32'(aw_addr_q), 32'h5);
        chkw("mem_data", w_data_q, 32'h12345678);

        // write by m0 with error response
        m0_aw_valid = 1'b1; m0_aw_address = 4'h2;
        m0_w_valid = 1'b1; m0_w_data = 32'hA5A5A5A5;
        step();
        chk1("err_wr_owner", wr_owner, 1'b0);
        s_aw_ready = 1'b1; s_w_ready = 1'b1;
        settle();
        chk1("err_m0_aw_ready", m0_aw_ready, 1'b1);
        chk1("err_m0_w_ready", m0_w_ready, 1'b1);
        chk1("err_m1_w_ready", m1_w_ready, 1'b0);
        step();
        idle_inputs();
        s_b_valid = 1'b1; s_b_resp = 1'b1; m0_b_ready = 1'b1; m1_b_ready = 1'b1;
        settle();
        chk1("err_m0_b_resp", m0_b_resp, 1'b1);
        chk1("err_m1_b_resp", m1_b_resp, 1'b0);
        chk1("err_m1_b_valid", m1_b_valid, 1'b0);
        step();
        idle_inputs();
        settle();
        chk1("err_wr_busy_done", wr_busy, 1'b0);

        // concurrent read by m0 and write by m1
        m0_ar_valid = 1'b1; m0_ar_address = 4'h7;
        m1_aw_valid = 1'b1; m1_aw_address = 4'h9;
        m1_w_valid = 1'b1; m1_w_data = 32'h0BADCAFE;
        step();
        chk1("cc_rd_busy", rd_busy, 1'b1);
        chk1("cc_wr_busy", wr_busy, 1'b1);
        chk1("cc_rd_owner", rd_owner, 1'b0);
        chk1("cc_wr_owner", wr_owner, 1'b1);
        s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;
        settle();
        chk1("cc_m0_ar_ready", m0_ar_ready, 1'b1);
        chk1("cc_m1_aw_ready", m1_aw_ready, 1'b1);
        chk1("cc_m1_w_ready", m1_w_ready, 1'b1);
        step();
        idle_inputs();
        s_r_valid = 1'b1; s_r_data = 32'h00000077; m0_r_ready = 1'b1;
        s_b_valid = 1'b1; m1_b_ready = 1'b1;
        settle();
        chk1("cc_m0_r_valid", m0_r_valid, 1'b1);
        chkw("cc_m0_r_data", m0_r_data, 32'h00000077);
        chk1("cc_m1_b_valid", m1_b_valid, 1'b1);
        chk1("cc_m1_r_valid", m1_r_valid, 1'b0);
        chk1("cc_m0_b_valid", m0_b_valid, 1'b0);
        step();
        idle_inputs();
        settle();
        chk1("cc_rd_done", rd_busy, 1'b0);
        chk1("cc_wr_done", wr_busy, 1'b0);

        // reset while the read path waits in its data phase
        m0_ar_valid = 1'b1; m0_ar_address = 4'h4;
        step();
        s_ar_ready = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1; s_r_valid = 1'b1; m0_r_ready = 1'b1;
        settle();
        chk1("rst_mid_busy_before", rd_busy, 1'b1);
        step();
        chk1("rst_mid_rd_busy", rd_busy, 1'b0);
        chk1("rst_mid_m0_r_valid", m0_r_valid, 1'b0);
        chk1("rst_mid_s_r_ready", s_r_ready, 1'b0);
        chk1("rst_mid_s_ar_valid", s_ar_valid, 1'b0);
        rst = 1'b0;
        idle_inputs();
        m1_ar_valid = 1'b1; m1_ar_address = 4'h8;
        step();
        chk1("post_rst_rd_busy", rd_busy, 1'b1);
        chk1("post_rst_rd_owner", rd_owner, 1'b1);
        chk1("post_rst_s_ar_valid", s_ar_valid, 1'b1);
        chkw("post_rst_s_ar_addr", 32'(s_ar_address), 32'h8);
        s_ar_ready = 1'b1;
        step();
        idle_inputs();
        s_r_valid = 1'b1; s_r_data = 32'h5A5A0001; m1_r_ready = 1'b1;
        settle();
        chkw("post_rst_m1_r_data", m1_r_data, 32'h5A5A0001);
        step();
        idle_inputs();
        settle();
        chk1("post_rst_rd_done", rd_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2x1.md
# mem_arbiter_2x1

Two-requester arbiter sharing the single-port memory's AXI-lite-style channel set (AR/R, AW/W/B) between two masters, e.g. `sort_circuit` and a loader/checker. Read and write paths are arbitrated independently, each locked to one master from address handshake until response handshake. It sits between the masters and `memory`, replacing the direct point-to-point connection.

## Interface
- `ADDR_WDTH`, 4, address width
- `DATA_WDTH`, 32, data width
- `RESP_WDTH`, 1, response width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `mN_ar_valid / mN_ar_ready / mN_ar_address`  in/out/in  1/1/ADDR_WDTH  read address, master N (N=0,1)
- `mN_r_valid / mN_r_ready / mN_r_data / mN_r_resp`  out/in/out/out  1/1/DATA_WDTH/RESP_WDTH  read data, master N
- `mN_aw_valid / mN_aw_ready / mN_aw_address`  in/out/in  1/1/ADDR_WDTH  write address, master N
- `mN_w_valid / mN_w_ready / mN_w_data`  in/out/in  1/1/DATA_WDTH  write data, master N
- `mN_b_valid / mN_b_ready / mN_b_resp`  out/in/out  1/1/RESP_WDTH  write response, master N
- `s_ar_* , s_r_* , s_aw_* , s_w_* , s_b_*`  mirrored directions  same widths  memory-side channels
- `rd_owner`  out  1  current read grant index (valid when `rd_busy`)
- `rd_busy`  out  1  read path locked
- `wr_owner`  out  1  current write grant index
- `wr_busy`  out  1  write path locked

## Operation
- Read FSM: `RD_IDLE` -> `RD_ADDR` -> `RD_DATA` -> `RD_IDLE`.
  - In `RD_IDLE`: if any `mN_ar_valid`, register winner into `rd_owner` and go to `RD_ADDR`.
  - In `RD_ADDR`: owner's AR passes through (`s_ar_valid = m_ar_valid[owner]`, `m_ar_ready[owner] = s_ar_ready`); on `s_ar_valid & s_ar_ready` go to `RD_DATA`.
  - In `RD_DATA`: R routed to owner; on `s_r_valid & s_r_ready` return to `RD_IDLE` and update priority.
- Write FSM: `WR_IDLE` -> `WR_XFER` -> `WR_RESP` -> `WR_IDLE`.
  - Arbitration on `mN_aw_valid`.
  - In `WR_XFER`: AW and W pass through independently. Flags `aw_done` / `w_done` set on their handshakes; once both are set (same or different cycles), go to `WR_RESP` and clear the flags. A channel whose flag is set has valid/ready forced to 0.
  - `WR_RESP`: B routed to owner; on handshake return to `WR_IDLE`.
- Non-owner and idle paths: all master-side readys/valids 0, `s_*_valid` 0, `s_*_address` / `s_w_data` 0.
- Response data/resp buses for the non-owner are 0.
- Arbitration: round-robin per path.
  - Winner is the requester not granted last; if only one requests, it wins.
  - Pointer is updated at response completion.
  - Reset pointer makes m0 win the first tie.
- A master dropping valid before its handshake is a protocol error; the grant is held regardless.
- The same master may own the read and write paths simultaneously.
- Reset mid-transaction: both FSMs to IDLE, flags cleared, pointers to reset value, all outputs 0. The in-flight memory transaction is abandoned.

## Timing
- Reset values: every output 0; `rd_owner` = `wr_owner` = 0; `rd_busy` = `wr_busy` = 0.
- Arbitration latency is 1 cycle: valid sampled in IDLE, forwarded the next cycle.
- Pass-through in XFER/ADDR/DATA/RESP states is combinational, zero cycles.
- `busy` is high from the cycle after request through the response handshake cycle's edge.
- Back-to-back: minimum one IDLE cycle between transactions on a path.
- Minimum read occupancy 3 cycles (IDLE, ADDR, DATA with immediate handshakes). Write minimum is also 3.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin as above.
- `MEM_ARB_RR_EN` undefined: fixed priority, m0 always wins ties; the pointer logic is compiled out.

## Structure
- Package `mem_arb_pkg`:
  - read/write state encodings (2-bit each)
  - master index typedef (1 bit)
  - reset pointer constant
- Sub-module `mem_arb_rr_picker`: 2-way picker with request vector, update strobe and winner index. Instantiated once for read, once for write.

## Test plan
- Single read: m0 AR addr 4'h3, memory returns 32'hDEADBEEF resp 0 -> m0 receives data; m1_r_valid stays 0; `rd_busy` high for exactly 2 cycles.
- Simultaneous AR from m0 (addr 1) and m1 (addr 2), repeated twice -> grant order m0, m1, m0, m1 with RR on; m0, m0, … without `MEM_ARB_RR_EN`.
- Write with W before AW: m1 w_data 32'h12345678 one cycle, AW addr 5 two cycles later -> single s_aw and s_w handshake each; m1 gets `b_resp` 0; memory[5] == 32'h12345678.
- Concurrent read by m0 and write by m1 -> both complete independently; neither path stalls the other.
- `always_error` = 1 on memory -> `b_resp` / `r_resp` = 1 routed to the owner only.
- `rst` asserted during `RD_DATA` -> next cycle all outputs 0 and `rd_busy` = 0; a fresh m1 request is granted 1 cycle after deassertion.
